// File: rtl/vec_decode_queue_if.sv
// Issue/decode bundle between the scalar core, the vector instruction queue
// and the vector register file / LSU. clk and reset stay plain module ports.
interface vec_decode_queue_if #(
    parameter int XLEN = 32
);
    // issue side
    logic            flush;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] vec_inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            is_vec;

    // decode side
    logic            dec_valid;
    logic            dec_ready;
    logic [1:0]      dec_class;
    logic [4:0]      vs1_addr;
    logic [4:0]      vs2_addr;
    logic [4:0]      vd_addr;
    logic [XLEN-1:0] vec_imm;
    logic            vec_mask;
    logic [XLEN-1:0] scalar_op;
    logic [XLEN-1:0] stride;
    logic [2:0]      width;
    logic [2:0]      nf;
    logic            mew;

    // architectural vector CSR state
    logic [XLEN-1:0] vl;
    logic [XLEN-1:0] vtype;
    logic            vill;

    // core / testbench side
    modport master (
        output flush, inst_valid, vec_inst, rs1_data, rs2_data, dec_ready,
        input  inst_ready, is_vec, dec_valid, dec_class, vs1_addr, vs2_addr,
               vd_addr, vec_imm, vec_mask, scalar_op, stride, width, nf, mew,
               vl, vtype, vill
    );

    // queue side
    modport slave (
        input  flush, inst_valid, vec_inst, rs1_data, rs2_data, dec_ready,
        output inst_ready, is_vec, dec_valid, dec_class, vs1_addr, vs2_addr,
               vd_addr, vec_imm, vec_mask, scalar_op, stride, width, nf, mew,
               vl, vtype, vill
    );
endinterface

// File: rtl/vec_decode_queue.sv
// Vector instruction queue: buffers vector instructions with their scalar
// operands, decodes the head entry combinationally and retires vset*
// instructions in order into the vl/vtype state.
module vec_decode_queue #(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    vec_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    // wide enough for VLEN * 8 before dividing by SEW
    localparam int VW = $clog2(VLEN) + 4;

    localparam logic [6:0] OP_V  = 7'h57;
    localparam logic [6:0] OP_LD = 7'h07;
    localparam logic [6:0] OP_ST = 7'h27;

    localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] rs1_mem  [DEPTH];
    logic [XLEN-1:0] rs2_mem  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic empty;
    logic is_vec;
    logic push;
    logic pop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign is_vec = (bus.vec_inst[6:0] == OP_V) ||
                    (bus.vec_inst[6:0] == OP_LD) ||
                    (bus.vec_inst[6:0] == OP_ST);
    // a flush in the same cycle wins over an incoming instruction
    assign push   = bus.inst_valid && !full && is_vec && !bus.flush;
    assign pop    = !empty && bus.dec_ready;

    // Payload write; storage carries no reset since validity lives in count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.vec_inst;
            rs1_mem[wr_ptr]  <= bus.rs1_data;
            rs2_mem[wr_ptr]  <= bus.rs2_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Head entry fields
    // ------------------------------------------------------------------
    logic [XLEN-1:0] head_inst;
    logic [XLEN-1:0] head_rs1;
    logic [XLEN-1:0] head_rs2;

    assign head_inst = inst_mem[rd_ptr];
    assign head_rs1  = rs1_mem[rd_ptr];
    assign head_rs2  = rs2_mem[rd_ptr];

    logic [6:0] h_opcode;
    logic [2:0] h_funct3;
    logic [4:0] h_rd;
    logic [4:0] h_rs1;
    logic [4:0] h_rs2;
    logic [1:0] h_mop;
    logic       h_is_cfg;

    assign h_opcode = head_inst[6:0];
    assign h_rd     = head_inst[11:7];
    assign h_funct3 = head_inst[14:12];
    assign h_rs1    = head_inst[19:15];
    assign h_rs2    = head_inst[24:20];
    assign h_mop    = head_inst[27:26];
    assign h_is_cfg = (h_opcode == OP_V) && (h_funct3 == 3'b111);

    // ------------------------------------------------------------------
    // Head decode; every field is zero while the queue is empty
    // ------------------------------------------------------------------
    logic [1:0]      dec_class;
    logic [4:0]      vs1_addr;
    logic [4:0]      vs2_addr;
    logic [4:0]      vd_addr;
    logic [XLEN-1:0] vec_imm;
    logic            vec_mask;
    logic [XLEN-1:0] scalar_op;
    logic [XLEN-1:0] stride;
    logic [2:0]      width;
    logic [2:0]      nf;
    logic            mew;

    // Field extraction by opcode / funct3 / mop from the head entry.
    always_comb begin
        dec_class = 2'd0;
        vs1_addr  = '0;
        vs2_addr  = '0;
        vd_addr   = '0;
        vec_imm   = '0;
        vec_mask  = 1'b0;
        scalar_op = '0;
        stride    = '0;
        width     = '0;
        nf        = '0;
        mew       = 1'b0;
        if (!empty) begin
            case (h_opcode)
                OP_V: begin
                    case (h_funct3)
                        3'b000: begin // OPIVV
                            vs1_addr = h_rs1;
                            vs2_addr = h_rs2;
                            vd_addr  = h_rd;
                            vec_mask = head_inst[25];
                        end
                        3'b011: begin // OPIVI
                            vs2_addr = h_rs2;
                            vd_addr  = h_rd;
                            vec_imm  = {{(XLEN-5){head_inst[19]}}, head_inst[19:15]};
                            vec_mask = head_inst[25];
                        end
                        3'b100: begin // OPIVX
                            vs2_addr  = h_rs2;
                            vd_addr   = h_rd;
                            scalar_op = head_rs1;
                            vec_mask  = head_inst[25];
                        end
                        3'b111: begin // vset* configuration
                            dec_class = 2'd3;
                        end
                        default: begin // unsupported arithmetic: class 0, no operands
                            dec_class = 2'd0;
                        end
                    endcase
                end
                OP_LD, OP_ST: begin
                    dec_class = (h_opcode == OP_LD) ? 2'd1 : 2'd2;
                    vd_addr   = h_rd;   // vs3 for stores
                    scalar_op = head_rs1;
                    vec_mask  = head_inst[25];
                    width     = h_funct3;
                    mew       = head_inst[28];
                    nf        = head_inst[31:29];
                    if (h_mop == 2'b10) begin
                        stride = head_rs2;
                    end
                    if (h_mop[0]) begin
                        vs2_addr = h_rs2; // index register
                    end
                end
                default: begin
                    dec_class = 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // vset* evaluation for the head entry
    // ------------------------------------------------------------------
    logic [XLEN-1:0] vl;
    logic [XLEN-1:0] vtype;

    logic [XLEN-1:0] cfg_vtype_req;
    logic [2:0]      cfg_vsew;
    logic [2:0]      cfg_vlmul;
    logic [1:0]      lmul_up;
    logic [2:0]      lmul_dn;
    logic [3:0]      sew_sh;
    logic [VW-1:0]   vlmax_wide;
    logic [XLEN-1:0] vlmax;
    logic            cfg_illegal;
    logic [XLEN-1:0] cfg_avl;
    logic [XLEN-1:0] cfg_vl;
    logic [XLEN-1:0] cfg_vtype;

    // Requested vtype by variant: vsetvli (zimm11), vsetivli (zimm10), vsetvl (rs2).
    always_comb begin
        if (!head_inst[31]) begin
            cfg_vtype_req = {{(XLEN-11){1'b0}}, head_inst[30:20]};
        end else if (head_inst[30]) begin
            cfg_vtype_req = {{(XLEN-10){1'b0}}, head_inst[29:20]};
        end else begin
            cfg_vtype_req = head_rs2;
        end
    end

    assign cfg_vsew  = cfg_vtype_req[5:3];
    assign cfg_vlmul = cfg_vtype_req[2:0];

    // VLMAX = VLEN * LMUL / SEW, with LMUL as a left or right shift.
    always_comb begin
        lmul_up    = cfg_vlmul[2] ? 2'd0 : cfg_vlmul[1:0];
        lmul_dn    = cfg_vlmul[2] ? (3'd4 - {1'b0, cfg_vlmul[1:0]}) : 3'd0;
        sew_sh     = 4'd3 + {1'b0, cfg_vsew};
        vlmax_wide = ((VW'(VLEN) << lmul_up) >> lmul_dn) >> sew_sh;
        vlmax      = XLEN'(vlmax_wide);
    end

    // Legality and resulting vl: AVL source depends on variant and rs1/rd.
    always_comb begin
        cfg_illegal = (cfg_vsew > 3'd3) || (cfg_vlmul == 3'b100) ||
                      (vlmax == '0) || (|cfg_vtype_req[XLEN-2:8]) ||
                      cfg_vtype_req[XLEN-1];
        if (head_inst[31:30] == 2'b11) begin
            cfg_avl = {{(XLEN-5){1'b0}}, h_rs1};
        end else if (h_rs1 != 5'd0) begin
            cfg_avl = head_rs1;
        end else if (h_rd != 5'd0) begin
            cfg_avl = vlmax;
        end else begin
            cfg_avl = vl; // keep current vl, clamped below
        end
        if (cfg_illegal) begin
            cfg_vl    = '0;
            cfg_vtype = VTYPE_ILL;
        end else begin
            cfg_vl    = (cfg_avl < vlmax) ? cfg_avl : vlmax;
            cfg_vtype = cfg_vtype_req;
        end
    end

    // vl/vtype retire in order when a vset* leaves the queue, flush or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vl    <= '0;
            vtype <= VTYPE_ILL;
        end else if (pop && h_is_cfg) begin
            vl    <= cfg_vl;
            vtype <= cfg_vtype;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.inst_ready = !full;
    assign bus.is_vec     = is_vec;
    assign bus.dec_valid  = !empty;
    assign bus.dec_class  = dec_class;
    assign bus.vs1_addr   = vs1_addr;
    assign bus.vs2_addr   = vs2_addr;
    assign bus.vd_addr    = vd_addr;
    assign bus.vec_imm    = vec_imm;
    assign bus.vec_mask   = vec_mask;
    assign bus.scalar_op  = scalar_op;
    assign bus.stride     = stride;
    assign bus.width      = width;
    assign bus.nf         = nf;
    assign bus.mew        = mew;
    assign bus.vl         = vl;
    assign bus.vtype      = vtype;
    assign bus.vill       = vtype[XLEN-1];
endmodule

// File: tb/tb_vec_decode_queue.sv
// Self-checking bench for vec_decode_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_vec_decode_queue;
    localparam int XLEN  = 32;
    localparam int VLEN  = 512;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    vec_decode_queue_if #(.XLEN(XLEN)) bus ();

    vec_decode_queue #(.XLEN(XLEN), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        logic [31:0] imm;
        logic        mask;
        logic [31:0] scalar;
        logic [31:0] stride;
        logic [2:0]  width;
        logic [2:0]  nf;
        logic        mew;
    } exp_t;

    entry_t      q[$];
    logic [31:0] m_vl;
    logic [31:0] m_vtype;
    int          n_checks;
    int          n_fail;
    int          n_pops;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_opivv(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
        return {6'b000000, 1'b1, vs2, vs1, 3'b000, vd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_opivi(input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] imm);
        return {6'b000000, 1'b1, vs2, imm, 3'b011, vd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_ldst(input logic [6:0] op, input logic [2:0] nf, input logic mew,
                                             input logic [1:0] mop, input logic vm, input logic [4:0] f2,
                                             input logic [4:0] rs1, input logic [2:0] w, input logic [4:0] vd);
        return {nf, mew, mop, vm, f2, rs1, w, vd, op};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit model_is_vec(input logic [31:0] inst);
        return (inst[6:0] == 7'h57) || (inst[6:0] == 7'h07) || (inst[6:0] == 7'h27);
    endfunction

    function automatic exp_t model_decode();
        exp_t        e;
        logic [31:0] i;
        e = '{cls: 2'd0, vs1: 5'd0, vs2: 5'd0, vd: 5'd0, imm: 32'd0, mask: 1'b0,
              scalar: 32'd0, stride: 32'd0, width: 3'd0, nf: 3'd0, mew: 1'b0};
        if (q.size() == 0) return e;
        i = q[0].inst;
        if (i[6:0] == 7'h57) begin
            if (i[14:12] == 3'b111) begin
                e.cls = 2'd3;
            end else if (i[14:12] == 3'b000) begin
                e.vs1 = i[19:15]; e.vs2 = i[24:20]; e.vd = i[11:7]; e.mask = i[25];
            end else if (i[14:12] == 3'b011) begin
                e.vs2 = i[24:20]; e.vd = i[11:7]; e.mask = i[25];
                e.imm = 32'($signed(i[19:15]));
            end else if (i[14:12] == 3'b100) begin
                e.vs2 = i[24:20]; e.vd = i[11:7]; e.mask = i[25]; e.scalar = q[0].rs1;
            end
        end else begin
            e.cls    = (i[6:0] == 7'h07) ? 2'd1 : 2'd2;
            e.vd     = i[11:7];
            e.scalar = q[0].rs1;
            e.mask   = i[25];
            e.width  = i[14:12];
            e.mew    = i[28];
            e.nf     = i[31:29];
            if (i[27:26] == 2'b10) e.stride = q[0].rs2;
            if (i[27:26] == 2'b01 || i[27:26] == 2'b11) e.vs2 = i[24:20];
        end
        return e;
    endfunction

    // vl/vtype update from the RVV rules, using plain integer arithmetic.
    task automatic model_config(input entry_t e);
        logic [31:0] i;
        logic [31:0] vt;
        int          sew;
        int          num;
        int          den;
        longint      vlmax;
        longint      avl;
        bit          ill;
        i   = e.inst;
        ill = 0;
        num = 1;
        den = 1;
        sew = 8;
        if (i[31] == 1'b0)        vt = {21'd0, i[30:20]};
        else if (i[30] == 1'b1)   vt = {22'd0, i[29:20]};
        else                      vt = e.rs2;
        if (vt[5:3] > 3) ill = 1;
        else sew = 8 << vt[5:3];
        case (vt[2:0])
            3'd0: begin num = 1; den = 1; end
            3'd1: begin num = 2; den = 1; end
            3'd2: begin num = 4; den = 1; end
            3'd3: begin num = 8; den = 1; end
            3'd5: begin num = 1; den = 8; end
            3'd6: begin num = 1; den = 4; end
            3'd7: begin num = 1; den = 2; end
            default: ill = 1;
        endcase
        vlmax = (longint'(VLEN) * num) / (sew * den);
        if (vlmax == 0) ill = 1;
        if (vt[30:8] != 0 || vt[31]) ill = 1;
        if (ill) begin
            m_vl    = 32'd0;
            m_vtype = 32'h8000_0000;
        end else begin
            if (i[31:30] == 2'b11)       avl = longint'(i[19:15]);
            else if (i[19:15] != 0)      avl = longint'(e.rs1);
            else if (i[11:7] != 0)       avl = vlmax;
            else                         avl = longint'(m_vl);
            m_vl    = 32'((avl < vlmax) ? avl : vlmax);
            m_vtype = vt;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vl    = 32'd0;
        m_vtype = 32'h8000_0000;
    endtask

    task automatic model_step(input logic iv, input logic [31:0] inst, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic rdy, input logic fl);
        bit     psh;
        bit     pp;
        entry_t h;
        entry_t d;
        psh = iv && (q.size() < DEPTH) && model_is_vec(inst) && !fl;
        pp  = (q.size() > 0) && rdy;
        if (pp) begin
            h = q[0];
            n_pops++;
            if (h.inst[6:0] == 7'h57 && h.inst[14:12] == 3'b111) model_config(h);
            $display("pop %0d: inst=%08h rs1=%08h rs2=%08h class=%0d vl=%0d vtype=%08h",
                     n_pops, h.inst, h.rs1, h.rs2, bus.dec_class, m_vl, m_vtype);
        end
        if (fl) begin
            q.delete();
        end else begin
            if (pp) d = q.pop_front();
            if (psh) q.push_back('{inst: inst, rs1: rs1, rs2: rs2});
        end
    endtask

    task automatic compare_all();
        exp_t e;
        e = model_decode();
        check_value("inst_ready", 32'(bus.inst_ready), 32'(q.size() < DEPTH));
        check_value("dec_valid",  32'(bus.dec_valid),  32'(q.size() > 0));
        check_value("is_vec",     32'(bus.is_vec),     32'(model_is_vec(bus.vec_inst)));
        check_value("dec_class",  32'(bus.dec_class),  32'(e.cls));
        check_value("vs1_addr",   32'(bus.vs1_addr),   32'(e.vs1));
        check_value("vs2_addr",   32'(bus.vs2_addr),   32'(e.vs2));
        check_value("vd_addr",    32'(bus.vd_addr),    32'(e.vd));
        check_value("vec_imm",    bus.vec_imm,         e.imm);
        check_value("vec_mask",   32'(bus.vec_mask),   32'(e.mask));
        check_value("scalar_op",  bus.scalar_op,       e.scalar);
        check_value("stride",     bus.stride,          e.stride);
        check_value("width",      32'(bus.width),      32'(e.width));
        check_value("nf",         32'(bus.nf),         32'(e.nf));
        check_value("mew",        32'(bus.mew),        32'(e.mew));
        check_value("vl",         bus.vl,              m_vl);
        check_value("vtype",      bus.vtype,           m_vtype);
        check_value("vill",       32'(bus.vill),       32'(m_vtype[31]));
    endtask

    // One clock: drive inputs, compare, advance the model, end at the next negedge.
    task automatic cyc(input logic iv, input logic [31:0] inst, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic rdy, input logic fl);
        bus.inst_valid = iv;
        bus.vec_inst   = inst;
        bus.rs1_data   = rs1;
        bus.rs2_data   = rs2;
        bus.dec_ready  = rdy;
        bus.flush      = fl;
        #1;
        compare_all();
        model_step(iv, inst, rs1, rs2, rdy, fl);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    // ---------------- random instruction generator ----------------
    function automatic logic [31:0] rand_inst();
        int          r;
        logic [10:0] zimm;
        logic [2:0]  f3;
        r    = $urandom_range(0, 9);
        zimm = {(($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0), 2'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        case (r)
            0, 1, 2: begin
                case ($urandom_range(0, 3))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b011;
                    2:       f3 = 3'b100;
                    default: f3 = 3'($urandom);
                endcase
                if (f3 == 3'b111) f3 = 3'b001;
                return {6'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h57};
            end
            3: begin
                case ($urandom_range(0, 2))
                    0:       return enc_vsetvli(5'($urandom_range(0, 1)), 5'($urandom_range(0, 2)), zimm);
                    1:       return enc_vsetivli(5'($urandom), 5'($urandom), zimm[9:0]);
                    default: return enc_vsetvl(5'($urandom_range(0, 1)), 5'($urandom_range(0, 2)), 5'($urandom));
                endcase
            end
            4, 5: return enc_ldst(7'h07, 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                                  5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            6, 7: return enc_ldst(7'h27, 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                                  5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            8:    return {25'($urandom), 7'h33};
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_pops   = 0;
        bus.inst_valid = 1'b0;
        bus.vec_inst   = 32'd0;
        bus.rs1_data   = 32'd0;
        bus.rs2_data   = 32'd0;
        bus.dec_ready  = 1'b0;
        bus.flush      = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check_value("rst_vtype", bus.vtype, 32'h8000_0000);
        check_value("rst_vl", bus.vl, 32'd0);
        check_value("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        reset = 1'b0;

        // 1: vsetvli x1,x2,e32,m1 with AVL 100
        cyc(1'b1, enc_vsetvli(5'd1, 5'd2, 11'h010), 32'd100, 32'd0, 1'b0, 1'b0);
        idle(1'b1);
        check_value("t1_vtype", bus.vtype, 32'h0000_0010);
        check_value("t1_vl", bus.vl, 32'd16);
        check_value("t1_vill", 32'(bus.vill), 32'd0);

        // 2: fill the queue, pop once while also offering, then drain in order
        for (int k = 0; k < 4; k++)
            cyc(1'b1, enc_opivv(5'(k + 1), 5'(k + 8), 5'(k + 16)), 32'd0, 32'd0, 1'b0, 1'b0);
        check_value("t2_full_ready", 32'(bus.inst_ready), 32'd0);
        cyc(1'b1, enc_opivv(5'd31, 5'd31, 5'd31), 32'd0, 32'd0, 1'b1, 1'b0);
        check_value("t2_ready_after_pop", 32'(bus.inst_ready), 32'd1);
        for (int k = 1; k < 4; k++) begin
            check_value("t2_order_vd", 32'(bus.vd_addr), 32'(k + 1));
            check_value("t2_order_vs1", 32'(bus.vs1_addr), 32'(k + 8));
            idle(1'b1);
        end
        check_value("t2_drained", 32'(bus.dec_valid), 32'd0);

        // 3: vsetivli uimm=5 e8 m1, then vsetvl with reserved vlmul
        cyc(1'b1, enc_vsetivli(5'd0, 5'd5, 10'h000), 32'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check_value("t3_vl_ivli", bus.vl, 32'd5);
        cyc(1'b1, enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd50, 32'h0000_0004, 1'b1, 1'b0);
        idle(1'b1);
        check_value("t3_vill", 32'(bus.vill), 32'd1);
        check_value("t3_vl", bus.vl, 32'd0);
        check_value("t3_vtype", bus.vtype, 32'h8000_0000);

        // 4: x0/x0 keeps vl, clamped to the new VLMAX
        cyc(1'b1, enc_vsetvli(5'd1, 5'd2, 11'h010), 32'd100, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        cyc(1'b1, enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check_value("t4_keep_vl", bus.vl, 32'd16);
        cyc(1'b1, enc_vsetvli(5'd0, 5'd0, 11'h018), 32'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check_value("t4_clamp_vl", bus.vl, 32'd8);

        // 5: strided load, then OPIVI with all-ones immediate
        cyc(1'b1, enc_ldst(7'h07, 3'd0, 1'b0, 2'b10, 1'b1, 5'd2, 5'd3, 3'b110, 5'd4),
            32'h0000_1000, 32'd8, 1'b0, 1'b0);
        check_value("t5_class", 32'(bus.dec_class), 32'd1);
        check_value("t5_scalar", bus.scalar_op, 32'h0000_1000);
        check_value("t5_stride", bus.stride, 32'd8);
        cyc(1'b1, enc_opivi(5'd5, 5'd6, 5'b11111), 32'd0, 32'd0, 1'b1, 1'b0);
        check_value("t5_imm", bus.vec_imm, 32'hFFFF_FFFF);
        idle(1'b1);

        // 6: non-vector opcode is dropped; flush with a simultaneous push
        cyc(1'b1, 32'h00B5_0533, 32'd1, 32'd2, 1'b0, 1'b0);
        check_value("t6_is_vec", 32'(bus.is_vec), 32'd0);
        check_value("t6_no_push", 32'(bus.dec_valid), 32'd0);
        for (int k = 0; k < 3; k++)
            cyc(1'b1, enc_opivv(5'(k), 5'(k), 5'(k)), 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, enc_opivv(5'd9, 5'd9, 5'd9), 32'd0, 32'd0, 1'b0, 1'b1);
        check_value("t6_flush_empty", 32'(bus.dec_valid), 32'd0);
        check_value("t6_flush_vl", bus.vl, 32'd8);

        // flush together with a config pop still applies the config (e16 m1, AVL 7)
        cyc(1'b1, enc_vsetvli(5'd1, 5'd2, 11'h008), 32'd7, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        check_value("flush_cfg_vl", bus.vl, 32'd7);
        check_value("flush_cfg_vtype", bus.vtype, 32'h0000_0008);

        // asynchronous reset in the middle of traffic
        cyc(1'b1, enc_opivv(5'd1, 5'd2, 5'd3), 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, enc_opivv(5'd4, 5'd5, 5'd6), 32'd0, 32'd0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_value("arst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check_value("arst_vl", bus.vl, 32'd0);
        check_value("arst_vtype", bus.vtype, 32'h8000_0000);
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] inst;
            logic [31:0] rs2;
            inst = rand_inst();
            rs2  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
            cyc(1'($urandom_range(0, 9) < 7), inst, 32'($urandom_range(0, 150)), rs2,
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_decode_queue.md
Name: vec_decode_queue

Overview:
Parametrised successor to the combinational vector decoder. Buffers vector instructions and their scalar operands from the scalar core in a DEPTH-entry FIFO. Decodes the head entry into register-file, load/store and operand fields. Owns the architectural vl/vtype state, updating it in order when vsetvli/vsetivli/vsetvl retire from the queue. Sits between the scalar processor's issue port and the vector register file / LSU.

Parameters:
XLEN, 32, scalar data / instruction width
VLEN, 512, vector register length in bits (power of two)
DEPTH, 4, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous queue flush
inst_valid  in  1  scalar core offers an instruction
inst_ready  out  1  queue can accept
vec_inst  in  XLEN  instruction word
rs1_data  in  XLEN  scalar rs1 value
rs2_data  in  XLEN  scalar rs2 value
is_vec  out  1  combinational: vec_inst opcode is 0x57, 0x07 or 0x27
dec_valid  out  1  head entry valid
dec_ready  in  1  downstream consumes head
dec_class  out  2  0=arith 1=load 2=store 3=config
vs1_addr, vs2_addr, vd_addr  out  5 each  register addresses
vec_imm  out  XLEN  sign-extended simm5 (OPIVI), else 0
vec_mask  out  1  vm bit
scalar_op  out  XLEN  rs1_data (OPIVX, load/store base), else 0
stride  out  XLEN  rs2_data when mop=2'b10, else 0
width, nf  out  3 each  load/store width, nf
mew  out  1  load/store mew
vl  out  XLEN  current vl CSR
vtype  out  XLEN  current vtype CSR
vill  out  1  vtype[XLEN-1]

Behaviour:
- Reset (async): FIFO empty, pointers 0, dec_valid=0, all dec_* fields 0, vl=0, vtype={1'b1,0...} (vill=1).
- Push when inst_valid & inst_ready & is_vec. inst_ready = !full, independent of opcode. A non-vector instruction offered with inst_ready=1 is consumed and dropped. Entry stores {vec_inst, rs1_data, rs2_data}.
- Full: inst_ready=0. No same-cycle bypass, so a pop while full does not allow a push in that cycle.
- Empty: dec_valid=0 and dec_* are 0. Push to an empty queue gives dec_valid=1 the next cycle (1-cycle latency).
- Pop when dec_valid & dec_ready. Simultaneous push and pop when neither full nor empty keeps the count unchanged. Pointers wrap modulo DEPTH.
- dec_* are decoded combinationally from the head entry only.
  - Arith funct3: OPIVV gives vs1 and vs2. OPIVI gives vs2 and imm. OPIVX gives vs2 and scalar_op.
  - Load/store: mop 10 drives stride; mop 01/11 drives vs2_addr; mop 00 gives vs2_addr=0. Store vd_addr carries vs3.
  - Unsupported arith funct3: dec_class=0, all address fields 0.
- Config (funct3=111) updates vl/vtype on its pop edge, so later entries see new values.
  - Variants: inst[31]=0 is vsetvli, new vtype = zimm inst[30:20] zero-extended. inst[31:30]=11 is vsetivli, vtype = inst[29:20], AVL = uimm inst[19:15]. inst[31:30]=10 is vsetvl, vtype = rs2_data.
  - SEW = 8<<vtype[5:3]; vsew>3 is illegal.
  - LMUL from vtype[2:0]: 000=1, 001=2, 010=4, 011=8, 101=1/8, 110=1/4, 111=1/2; 100 is illegal.
  - VLMAX = VLEN*LMUL/SEW, computed by shifts. VLMAX=0 (e.g. fractional LMUL below SEW/ELEN) is treated as illegal.
  - vill condition: illegal vsew/vlmul, VLMAX=0, or nonzero vtype[XLEN-2:8]. On vill: vtype={1,0...}, vl=0.
  - AVL for vsetvli/vsetvl: rs1_addr≠0 gives vl=min(rs1_data,VLMAX). rs1_addr=0 with rd≠0 gives vl=VLMAX. rs1_addr=0 with rd=0 keeps vl, clamped to the new VLMAX.
  - AVL for vsetivli: vl=min(uimm,VLMAX).
- flush: empties the FIFO next cycle. vl/vtype unchanged. Flush and push in the same cycle drops the push. Flush and pop of a config in the same cycle still applies the config.
- Reset mid-operation: immediate return to the reset state; in-flight entries are lost.

Test Plan:
1. Reset, then vsetvli x1,x2,e32,m1 with rs1_data=100, VLEN=512 -> after pop: vtype=0x010, vl=16, vill=0.
2. Push 4 OPIVV instructions with dec_ready=0 -> inst_ready=0 after the 4th. One pop -> inst_ready=1 the next cycle, and entries emerge in FIFO order with the correct vs1/vs2/vd.
3. vsetivli uimm=5, e8 m1 -> vl=5. Then vsetvl with rs2_data=0x004 (vlmul=100) -> vill=1, vl=0, vtype=0x80000000.
4. vsetvli x0,x0,e8 m1 when vl=16 -> vl=16. Then vsetvli x0,x0,e64 m1 -> vl=8 (clamped).
5. Strided load with mop=10, rs1_data=0x1000, rs2_data=8 -> dec_class=1, scalar_op=0x1000, stride=8. OPIVI with imm=5'b11111 -> vec_imm=0xFFFFFFFF.
6. Non-vector opcode 0x33 with inst_valid=1 -> is_vec=0 and no push. Flush with 3 entries queued plus a simultaneous push -> dec_valid=0 next cycle, vl unchanged.
